// File: rtl/prefix_add_pkg.sv
// prefix_add_pkg: helpers and payload types shared by the
// pipelined Kogge-Stone adder (prefix_adder_pipe).
package prefix_add_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_REG_EVERY = 2;
  localparam int MAX_WIDTH = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int levels_of(input int width);
    return clog2(width);
  endfunction

  function automatic int nstg_of(
    input int width,
    input int reg_every
  );
    return 1 + (levels_of(width) + reg_every - 1)
               / reg_every;
  endfunction

  localparam int LEVELS = levels_of(DEF_WIDTH);
  localparam int NSTG =
    nstg_of(DEF_WIDTH, DEF_REG_EVERY);

  // p/g: bitwise terms, pp/gg: group terms so far
  typedef struct packed {
    logic [MAX_WIDTH-1:0] p;
    logic [MAX_WIDTH-1:0] g;
    logic [MAX_WIDTH-1:0] pp;
    logic [MAX_WIDTH-1:0] gg;
    logic                 cin;
  } stage_t;

endpackage

// File: rtl/prefix_adder_pipe_level.sv
// prefix_level: one combinational Kogge-Stone level.
// Bits below DIST have no partner and pass through.
module prefix_level #(
  parameter int WIDTH = 32,
  parameter int DIST = 1
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] g_out
);

  // merge each bit with its partner DIST places below
  always_comb begin
    p_out = p_in;
    g_out = g_in;
    for (int i = DIST; i < WIDTH; i++) begin
      g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
      p_out[i] = p_in[i] & p_in[i-DIST];
    end
  end

endmodule

// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: elastic pipelined Kogge-Stone adder.
// Optional ovf output enabled by PREFIX_ADD_OVF_EN.
module prefix_adder_pipe
  import prefix_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PREFIX_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LVLS = levels_of(WIDTH);
  localparam int STGS = nstg_of(WIDTH, REG_EVERY);

  logic [STGS-1:0] v;
  logic [STGS-1:0] vin;
  logic [STGS-1:0] ld;
  logic [STGS:0]   rdy;

  // boundary values feeding stage s+1
  logic [WIDTH-1:0] bg  [STGS-1];
  logic [WIDTH-1:0] bp  [STGS-1];
  logic [WIDTH-1:0] bpb [STGS-1];
  logic             bc  [STGS-1];

  // stall chain: a stage is free if empty or draining
  always_comb begin
    rdy[STGS] = out_ready;
    for (int s = STGS - 1; s >= 0; s--)
      rdy[s] = !v[s] | rdy[s+1];
  end

  assign vin = {v[STGS-2:0], in_valid};
  assign ld = vin & rdy[STGS-1:0];
  assign in_ready = rdy[0];
  assign out_valid = v[STGS-1];

  // valid bits advance where ready, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v <= '0;
    else v <= ld | (~rdy[STGS-1:0] & v);
  end

  logic [WIDTH-1:0] ra, rb;
  logic             rc;

  // operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      rc <= 1'b0;
    end else if (ld[0]) begin
      ra <= a;
      rb <= b;
      rc <= cin;
    end
  end

  logic [WIDTH-1:0] p0, g0;
  assign p0 = ra ^ rb;
  assign g0 = ra & rb;

  // cin folded into bit 0 so G[i] is carry into i+1
  assign bg[0] = {g0[WIDTH-1:1],
                  g0[0] | (p0[0] & rc)};
  assign bp[0] = p0;
  assign bpb[0] = p0;
  assign bc[0] = rc;

  for (genvar s = 1; s < STGS; s++) begin : g_stg
    localparam int LO = (s - 1) * REG_EVERY;
    localparam int HI =
      (s * REG_EVERY < LVLS) ? s * REG_EVERY : LVLS;
    localparam int N = HI - LO;

    for (genvar j = 0; j < N; j++) begin : g_lvl
      logic [WIDTH-1:0] pi, gi, po, go;
      if (j == 0) begin : g_first
        assign pi = bp[s-1];
        assign gi = bg[s-1];
      end else begin : g_next
        assign pi = g_lvl[j-1].po;
        assign gi = g_lvl[j-1].go;
      end
      prefix_level #(
        .WIDTH(WIDTH),
        .DIST (1 << (LO + j))
      ) u_lvl (
        .p_in (pi),
        .g_in (gi),
        .p_out(po),
        .g_out(go)
      );
    end

    logic [WIDTH-1:0] pf, gf;
    assign pf = g_lvl[N-1].po;
    assign gf = g_lvl[N-1].go;

    if (s < STGS - 1) begin : g_mid
      logic [WIDTH-1:0] qg, qp, qpb;
      logic             qc;

      // group terms registered between level groups
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          qg <= '0;
          qp <= '0;
          qpb <= '0;
          qc <= 1'b0;
        end else if (ld[s]) begin
          qg <= gf;
          qp <= pf;
          qpb <= bpb[s-1];
          qc <= bc[s-1];
        end
      end

      assign bg[s] = qg;
      assign bp[s] = qp;
      assign bpb[s] = qpb;
      assign bc[s] = qc;
    end else begin : g_last
      logic [WIDTH-1:0] carry, p_unused;
      assign carry = {gf[WIDTH-2:0], bc[s-1]};
      assign p_unused = pf;

      // final sum and carries, held while stalled
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum <= '0;
          cout <= 1'b0;
`ifdef PREFIX_ADD_OVF_EN
          ovf <= 1'b0;
`endif
        end else if (ld[s]) begin
          sum <= bpb[s-1] ^ carry;
          cout <= gf[WIDTH-1];
`ifdef PREFIX_ADD_OVF_EN
          ovf <= gf[WIDTH-2] ^ gf[WIDTH-1];
`endif
        end
      end
    end
  end

endmodule
